inst_enc: RTL

- Instruction encoder: the inverse of the core's immediate generator. Packs an opcode, register/funct fields and a 32-bit signed immediate into a 32-bit RV32I instruction word.
- Used by the boot/test-program loader to stream encoded words into instruction memory. Each output word carries a wrapping word-address counter.
- Checks that each immediate is representable in the selected format. Flags errors and can optionally halt on them.

---
 rtl/inst_enc_if.sv | 55 +++++
 rtl/inst_enc.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_enc_if.sv
// -----------------------------------------------------------------------------
// inst_enc_if
//
// Purpose:
//   Bundles the input-field handshake and the encoded-word output handshake of
//   the instruction encoder. The loader drives the input side through the master
//   modport. The encoder block connects through the slave modport.
//
// Signals:
//   in_valid / in_ready   input-field handshake
//   imm_sel  [2:0]        immediate format: 000 I, 001 S, 010 B, 011 U, 110 J
//   opcode   [6:0]        inst[6:0]
//   rd       [4:0]        inst[11:7] for I/U/J
//   funct3   [2:0]        inst[14:12] for I/S/B
//   rs1      [4:0]        inst[19:15] for I/S/B
//   rs2      [4:0]        inst[24:20] for S/B
//   imm      [31:0]       signed byte-offset immediate
//   out_valid / out_ready encoded-word handshake
//   out_inst [31:0]       encoded instruction word
//   out_addr [ADDR_W-1:0] word address assigned to out_inst
//   out_err               immediate unencodable or imm_sel illegal
// -----------------------------------------------------------------------------
interface inst_enc_if #(
  parameter int ADDR_W = 10
);

  logic              in_valid;
  logic              in_ready;
  logic [2:0]        imm_sel;
  logic [6:0]        opcode;
  logic [4:0]        rd;
  logic [2:0]        funct3;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;

  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic              out_err;

  // Loader / test-program side: supplies fields and consumes encoded words.
  modport master (
    output in_valid, imm_sel, opcode, rd, funct3, rs1, rs2, imm, out_ready,
    input  in_ready, out_valid, out_inst, out_addr, out_err
  );

  // Encoder side.
  modport slave (
    input  in_valid, imm_sel, opcode, rd, funct3, rs1, rs2, imm, out_ready,
    output in_ready, out_valid, out_inst, out_addr, out_err
  );

endinterface

// File: rtl/inst_enc.sv
// -----------------------------------------------------------------------------
// inst_enc
//
// Purpose:
//   RV32I instruction encoder. This block is the inverse of the core's
//   immediate generator. It packs opcode, register/funct fields and a 32-bit
//   signed immediate into one instruction word. Each word is tagged with a
//   wrapping word address for the instruction-memory loader.
//   Immediates that the selected format cannot represent are flagged. When
//   HALT_ON_ERR is set, an erroring word that leaves the block halts intake
//   until a soft clear.
//
// Parameters:
//   ADDR_W       width of the word-address counter (wraps at 2^ADDR_W)
//   HALT_ON_ERR  1: an erroring output handshake moves the FSM to HALTED
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset, highest priority
//   clr         synchronous soft clear: counter, sticky error, HALTED -> RUN
//   bus         inst_enc_if.slave, input fields and output word handshakes
//   err_sticky  set by any erroring output handshake, cleared by rst/clr
//   halted      FSM is in HALTED
// -----------------------------------------------------------------------------
module inst_enc #(
  parameter int ADDR_W      = 10,
  parameter bit HALT_ON_ERR = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  inst_enc_if.slave    bus,
  output logic         err_sticky,
  output logic         halted
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  localparam logic [2:0] SEL_I = 3'b000;
  localparam logic [2:0] SEL_S = 3'b001;
  localparam logic [2:0] SEL_B = 3'b010;
  localparam logic [2:0] SEL_U = 3'b011;
  localparam logic [2:0] SEL_J = 3'b110;

  localparam logic [31:0] ILLEGAL_WORD = 32'hDEAD_BEEF;

  state_e            state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              out_err_q, out_err_d;
  logic [ADDR_W-1:0] addr_cnt_q, addr_cnt_d;
  logic              err_sticky_q, err_sticky_d;

  logic              in_ready;
  logic              in_hs;
  logic              out_hs;

  logic [31:0]       enc_inst;
  logic              enc_err;

  logic              fits_12;
  logic              fits_13;
  logic              fits_21;
  logic              low12_zero;

  // The output register is the only storage stage. A new word may enter
  // whenever it is empty or is being drained in this same cycle. This gives
  // one word per cycle under continuous out_ready.
  assign in_ready = (state_q == ST_RUN) && (!out_valid_q || bus.out_ready);
  assign in_hs    = bus.in_valid && in_ready;
  assign out_hs   = out_valid_q && bus.out_ready;

  // Range checks, expressed as "all bits above the field's sign bit match it".
  // A run of identical bits means the value sign-extends from the narrower
  // field without loss.
  assign fits_12    = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
  assign fits_13    = (&bus.imm[31:12]) || !(|bus.imm[31:12]);
  assign fits_21    = (&bus.imm[31:20]) || !(|bus.imm[31:20]);
  assign low12_zero = !(|bus.imm[11:0]);

  // Field packing per format. An out-of-range immediate is still packed from
  // its truncated bits, so the loader sees the word it would otherwise get.
  // Only the error flag tells the two cases apart.
  always_comb begin
    enc_inst = ILLEGAL_WORD;
    enc_err  = 1'b1;
    case (bus.imm_sel)
      SEL_I: begin
        enc_inst = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
        enc_err  = !fits_12;
      end
      SEL_S: begin
        enc_inst = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                    bus.imm[4:0], bus.opcode};
        enc_err  = !fits_12;
      end
      SEL_B: begin
        enc_inst = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                    bus.imm[4:1], bus.imm[11], bus.opcode};
        enc_err  = !fits_13 || bus.imm[0];
      end
      SEL_U: begin
        enc_inst = {bus.imm[31:12], bus.rd, bus.opcode};
        enc_err  = !low12_zero;
      end
      SEL_J: begin
        enc_inst = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                    bus.rd, bus.opcode};
        enc_err  = !fits_21 || bus.imm[0];
      end
      default: begin
        enc_inst = ILLEGAL_WORD;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Output register. It loads on an input handshake and empties on an output
  // handshake when nothing replaces it. The payload holds otherwise, so it
  // stays stable under backpressure.
  always_comb begin
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_addr_d  = out_addr_q;
    out_err_d   = out_err_q;
    if (in_hs) begin
      out_valid_d = 1'b1;
      out_inst_d  = enc_inst;
      out_addr_d  = addr_cnt_q;
      out_err_d   = enc_err;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end
  end

  // Word-address counter. A word accepted together with clr still takes the
  // pre-clear value as its address. The output register captures that value
  // as 0 only if the counter was already 0. Otherwise the clear would be
  // invisible to that word. So on clr the accepted word must see address 0.
  // That word is routed through the out_addr override below, and the counter
  // restarts at 1 after it.
  always_comb begin
    addr_cnt_d = addr_cnt_q;
    if (clr) begin
      addr_cnt_d = in_hs ? ADDR_W'(1) : '0;
    end else if (in_hs) begin
      addr_cnt_d = addr_cnt_q + ADDR_W'(1);
    end
  end

  // Sticky error flag. clr takes precedence over a coinciding erroring
  // handshake.
  always_comb begin
    err_sticky_d = err_sticky_q;
    if (clr) begin
      err_sticky_d = 1'b0;
    end else if (out_hs && out_err_q) begin
      err_sticky_d = 1'b1;
    end
  end

  // Run/halt FSM. HALTED blocks intake only. A word already held keeps
  // waiting for its output handshake, so nothing is dropped on a halt.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (!clr && HALT_ON_ERR && out_hs && out_err_q) begin
          state_d = ST_HALTED;
        end
      end
      ST_HALTED: begin
        if (clr) begin
          state_d = ST_RUN;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // State registers. rst overrides clr and any handshake. On clr the output
  // payload is left alone except for the address of a word loaded in the
  // same cycle, which restarts the numbering at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_RUN;
      out_valid_q  <= 1'b0;
      out_inst_q   <= '0;
      out_addr_q   <= '0;
      out_err_q    <= 1'b0;
      addr_cnt_q   <= '0;
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_inst_q   <= out_inst_d;
      out_addr_q   <= (clr && in_hs) ? '0 : out_addr_d;
      out_err_q    <= out_err_d;
      addr_cnt_q   <= addr_cnt_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_err   = out_err_q;
  assign err_sticky    = err_sticky_q;
  assign halted        = (state_q == ST_HALTED);

endmodule
